// File: rtl/encoder_2r5i_stream.sv
// LA32 2R5I shift-immediate encoder (SLLI.W / SRLI.W / SRAI.W) with a request FIFO.
// Each queued word carries its fetch address; rejected op codes are counted.

`ifndef _2R5I_SLLI
`define _2R5I_SLLI 2'b01
`endif
`ifndef _2R5I_SRLI
`define _2R5I_SRLI 2'b10
`endif
`ifndef _2R5I_SRAI
`define _2R5I_SRAI 2'b11
`endif
`ifndef INVALID_OP_2B
`define INVALID_OP_2B 2'b00
`endif

module encoder_2r5i_stream #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op_type,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rj,
  input  logic [4:0]       in_ui5,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             err_invalid,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  // Handshake: a request moves on a clk edge with in_valid && in_ready, a word
  // leaves on a clk edge with out_valid && out_ready; in_ready only reflects
  // registered occupancy, so a full FIFO never accepts even while popping.

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);

  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;

  logic [1:0]       op_field;
  logic             op_ok;
  logic [31:0]      word;
  logic             push_fire;
  logic             push_word;
  logic             push_bad;
  logic             pop_fire;

  // Op code is mapped to the instruction field, never passed through.
  always_comb begin
    op_field = 2'b00;
    op_ok    = 1'b1;
    case (in_op_type)
      `_2R5I_SLLI: op_field = 2'b00;
      `_2R5I_SRLI: op_field = 2'b01;
      `_2R5I_SRAI: op_field = 2'b10;
      default:     op_ok    = 1'b0;
    endcase
  end

  assign word = {12'b0000_0000_0100, op_field, 3'b001, in_ui5, in_rj, in_rd};

  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);

  assign push_fire = in_valid && in_ready && !rst;
  assign push_word = push_fire && op_ok;
  assign push_bad  = push_fire && !op_ok;
  assign pop_fire  = out_valid && out_ready;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    pc_d      = pc_q;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    err_d     = push_bad;

    if (push_word) begin
      tail_d = tail_q + PTR_ONE;
      pc_d   = pc_q + 32'd4;
      if (enc_cnt_q != '1) begin
        enc_cnt_d = enc_cnt_q + 1'b1;
      end
    end
    if (push_bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
    if (pop_fire) begin
      head_d = head_q + PTR_ONE;
    end

    case ({push_word, pop_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pc_q      <= BASE_ADDR;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: the read side is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push_word) begin
      instr_mem_q[tail_q] <= word;
      pc_mem_q[tail_q]    <= pc_q;
    end
  end

  assign out_instr   = out_valid ? instr_mem_q[head_q] : 32'h0;
  assign out_pc      = out_valid ? pc_mem_q[head_q]    : 32'h0;
  assign err_invalid = err_q;
  assign enc_count   = enc_cnt_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_encoder_2r5i_stream.sv
// Bench for encoder_2r5i_stream: directed scenarios plus random traffic against
// a queue-based reference model; a CNT_W=4 twin shares the inputs for saturation.

module tb_encoder_2r5i_stream;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h1C00_0000;
  localparam logic [1:0]  OP_SLLI = 2'b01;
  localparam logic [1:0]  OP_SRLI = 2'b10;
  localparam logic [1:0]  OP_SRAI = 2'b11;
  localparam logic [1:0]  OP_INV  = 2'b00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op_type = 2'b00;
  logic [4:0]  in_rd = '0, in_rj = '0, in_ui5 = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, err_invalid;
  logic [31:0] out_instr, out_pc;
  logic [15:0] enc_count, err_count;

  logic        s_in_ready, s_out_valid, s_err_invalid;
  logic [31:0] s_out_instr, s_out_pc;
  logic [3:0]  s_enc_count, s_err_count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  int unsigned m_enc, m_err;
  bit          m_pulse;
  bit          m_last_acc;

  always #5 clk = ~clk;

  encoder_2r5i_stream #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op_type(in_op_type), .in_rd(in_rd), .in_rj(in_rj), .in_ui5(in_ui5),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .err_invalid(err_invalid), .enc_count(enc_count), .err_count(err_count)
  );

  encoder_2r5i_stream #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op_type(in_op_type), .in_rd(in_rd), .in_rj(in_rj), .in_ui5(in_ui5),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_instr(s_out_instr), .out_pc(s_out_pc),
    .err_invalid(s_err_invalid), .enc_count(s_enc_count), .err_count(s_err_count)
  );

  function automatic logic [31:0] ref_encode(logic [1:0] op, logic [4:0] rd,
                                             logic [4:0] rj, logic [4:0] ui5);
    logic [31:0] kind;
    kind = (op == OP_SRLI) ? 32'd1 : (op == OP_SRAI) ? 32'd2 : 32'd0;
    return 32'h0040_0000 + kind * 32'h0004_0000 + 32'h0000_8000
         + 32'(ui5) * 32'd1024 + 32'(rj) * 32'd32 + 32'(rd);
  endfunction

  function automatic int unsigned sat(int unsigned v, int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [1:0] rand_valid_op();
    return 2'($urandom_range(1, 3));
  endfunction

  task automatic set_req(bit v, logic [1:0] op, logic [4:0] rd, logic [4:0] rj, logic [4:0] ui5);
    in_valid = v; in_op_type = op; in_rd = rd; in_rj = rj; in_ui5 = ui5;
  endtask

  task automatic set_rand_req(bit v, logic [1:0] op);
    set_req(v, op, 5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  // Advance one clock edge and apply the same edge to the model; returns at edge+1.
  task automatic tick();
    bit acc, pop, okop;
    logic [31:0] w;
    acc  = in_valid && (exp_q.size() < DEPTH) && !rst;
    pop  = (exp_q.size() != 0) && out_ready && !rst;
    okop = (in_op_type == OP_SLLI) || (in_op_type == OP_SRLI) || (in_op_type == OP_SRAI);
    w    = ref_encode(in_op_type, in_rd, in_rj, in_ui5);
    @(posedge clk);
    m_last_acc = acc && !rst;
    m_pulse    = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_pc = BASE; m_enc = 0; m_err = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc && okop) begin
        exp_q.push_back({w, m_pc});
        m_pc  = m_pc + 32'd4;
        m_enc = m_enc + 1;
      end else if (acc) begin
        m_pulse = 1'b1;
        m_err   = m_err + 1;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (err_invalid !== 1'b0) begin failures++; $display("FAIL reset_err_invalid got=%b exp=0", err_invalid); end
    checks++; if (enc_count !== 16'h0 || err_count !== 16'h0) begin failures++; $display("FAIL reset_counters got=%h/%h exp=0/0", enc_count, err_count); end
  endtask

  task automatic test_single_slli();
    apply_reset();
    out_ready = 1'b1;
    set_req(1'b1, OP_SLLI, 5'd1, 5'd2, 5'd3);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_instr !== 32'h0040_8C41) begin failures++; $display("FAIL single_instr got=%h exp=00408c41", out_instr); end
    checks++; if (out_pc !== 32'h1C00_0000) begin failures++; $display("FAIL single_pc got=%h exp=1c000000", out_pc); end
    checks++; if (enc_count !== 16'd1) begin failures++; $display("FAIL single_enc_count got=%0d exp=1", enc_count); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    set_req(1'b1, OP_SRLI, 5'd31, 5'd31, 5'd31);
    tick();
    checks++; if (out_instr !== 32'h0044_FFFF || out_pc !== 32'h1C00_0000) begin failures++; $display("FAIL b2b_first got=%h@%h exp=0044ffff@1c000000", out_instr, out_pc); end
    set_req(1'b1, OP_SRAI, 5'd4, 5'd5, 5'd16);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0048_C0A4 || out_pc !== 32'h1C00_0004) begin failures++; $display("FAIL b2b_second got=%b %h@%h exp=1 0048c0a4@1c000004", out_valid, out_instr, out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0 || enc_count !== 16'd2) begin failures++; $display("FAIL b2b_end got=%b cnt=%0d exp=0 cnt=2", out_valid, enc_count); end
  endtask

  task automatic test_invalid();
    apply_reset();
    set_rand_req(1'b1, OP_SLLI);
    tick();
    checks++; if (err_invalid !== 1'b0) begin failures++; $display("FAIL inv_pulse_pre got=%b exp=0", err_invalid); end
    set_rand_req(1'b1, OP_INV);
    tick();
    checks++; if (err_invalid !== 1'b1) begin failures++; $display("FAIL inv_pulse got=%b exp=1", err_invalid); end
    set_rand_req(1'b1, OP_SLLI);
    tick();
    in_valid = 1'b0;
    checks++; if (err_invalid !== 1'b0) begin failures++; $display("FAIL inv_pulse_width got=%b exp=0", err_invalid); end
    checks++; if (err_count !== 16'd1 || enc_count !== 16'd2) begin failures++; $display("FAIL inv_counts got=%0d/%0d exp=1/2", err_count, enc_count); end
    out_ready = 1'b1;
    checks++; if (out_pc !== 32'h1C00_0000 || out_instr !== exp_q[0][63:32]) begin failures++; $display("FAIL inv_word0 got=%h@%h exp=%h@1c000000", out_instr, out_pc, exp_q[0][63:32]); end
    tick();
    checks++; if (out_pc !== 32'h1C00_0004 || out_instr !== exp_q[0][63:32]) begin failures++; $display("FAIL inv_word1 got=%h@%h exp=%h@1c000004", out_instr, out_pc, exp_q[0][63:32]); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL inv_only_two got=%b exp=0", out_valid); end
  endtask

  task automatic test_fill();
    logic [31:0] first_word;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_rand_req(1'b1, rand_valid_op());
      tick();
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_full got=%b exp=0", in_ready); end
    first_word = exp_q[0][63:32];
    set_rand_req(1'b1, rand_valid_op());
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (in_ready !== 1'b0 || out_instr !== first_word || out_pc !== BASE) begin failures++; $display("FAIL fill_hold cyc=%0d got=%b %h@%h exp=0 %h@%h", i, in_ready, out_instr, out_pc, first_word, BASE); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_last_acc) in_valid = 1'b0;
      checks++; if (out_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL fill_drain_valid got=%b exp=%b", out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if ({out_instr, out_pc} !== exp_q[0]) begin failures++; $display("FAIL fill_drain_word got=%h@%h exp=%h@%h", out_instr, out_pc, exp_q[0][63:32], exp_q[0][31:0]); end
      end
      if (exp_q.size() == 0 && !in_valid) break;
    end
    checks++; if (in_valid !== 1'b0 || out_valid !== 1'b0 || enc_count !== 16'd5) begin failures++; $display("FAIL fill_done got=pend%b v%b cnt=%0d exp=pend0 v0 cnt=5", in_valid, out_valid, enc_count); end
  endtask

  task automatic test_stream();
    apply_reset();
    out_ready = 1'b1;
    set_rand_req(1'b1, rand_valid_op());
    tick();
    for (int i = 0; i < 10; i++) begin
      set_rand_req(1'b1, rand_valid_op());
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || {out_instr, out_pc} !== exp_q[0]) begin failures++; $display("FAIL stream cyc=%0d got=%b%b %h@%h exp=11 %h@%h", i, out_valid, in_ready, out_instr, out_pc, exp_q[0][63:32], exp_q[0][31:0]); end
    end
    in_valid = 1'b0;
    checks++; if (enc_count !== 16'd11 || out_pc !== BASE + 32'd40) begin failures++; $display("FAIL stream_count got=%0d pc=%h exp=11 pc=%h", enc_count, out_pc, BASE + 32'd40); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_rand_req(1'b1, rand_valid_op());
      tick();
    end
    rst = 1'b1;
    set_rand_req(1'b1, OP_SLLI);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_flags got=%b%b exp=01", out_valid, in_ready); end
    checks++; if (enc_count !== 16'd0 || err_count !== 16'd0 || out_pc !== 32'h0) begin failures++; $display("FAIL mid_rst_state got=%0d/%0d pc=%h exp=0/0 pc=0", enc_count, err_count, out_pc); end
    set_rand_req(1'b1, OP_SLLI);
    tick();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h1C00_0000 || enc_count !== 16'd1 || out_instr !== exp_q[0][63:32]) begin failures++; $display("FAIL mid_rst_next got=%h@%h cnt=%0d exp=%h@1c000000 cnt=1", out_instr, out_pc, enc_count, exp_q[0][63:32]); end
  endtask

  task automatic test_saturation();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_rand_req(1'b1, OP_INV);
      tick();
      checks++; if (err_invalid !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL sat_pulse i=%0d got=%b%b exp=10", i, err_invalid, out_valid); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (err_invalid !== 1'b0) begin failures++; $display("FAIL sat_pulse_end got=%b exp=0", err_invalid); end
    checks++; if (s_err_count !== 4'd15) begin failures++; $display("FAIL sat_small_err got=%0d exp=15", s_err_count); end
    checks++; if (err_count !== 16'd17) begin failures++; $display("FAIL sat_wide_err got=%0d exp=17", err_count); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_rand_req($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)));
      tick();
      checks++; if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() < DEPTH)) begin failures++; $display("FAIL rand_flags cyc=%0d got=%b%b exp=%b%b", i, out_valid, in_ready, exp_q.size() != 0, exp_q.size() < DEPTH); end
      if (exp_q.size() != 0) begin
        checks++; if ({out_instr, out_pc} !== exp_q[0]) begin failures++; $display("FAIL rand_word cyc=%0d got=%h@%h exp=%h@%h", i, out_instr, out_pc, exp_q[0][63:32], exp_q[0][31:0]); end
      end
      checks++; if (err_invalid !== m_pulse) begin failures++; $display("FAIL rand_err_pulse cyc=%0d got=%b exp=%b", i, err_invalid, m_pulse); end
      checks++; if (enc_count !== 16'(sat(m_enc, 65535)) || err_count !== 16'(sat(m_err, 65535))) begin failures++; $display("FAIL rand_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", i, enc_count, err_count, m_enc, m_err); end
      checks++; if (s_enc_count !== 4'(sat(m_enc, 15)) || s_err_count !== 4'(sat(m_err, 15))) begin failures++; $display("FAIL rand_small_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", i, s_enc_count, s_err_count, sat(m_enc, 15), sat(m_err, 15)); end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    m_pc = BASE; m_enc = 0; m_err = 0; m_pulse = 1'b0; m_last_acc = 1'b0;
    test_reset();
    test_single_slli();
    test_back_to_back();
    test_invalid();
    test_fill();
    test_stream();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
